// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point add/subtract with valid/ready handshake and flags.
// Build option: define FPADD_RNE_EN for round-to-nearest-even; otherwise round toward zero.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int XLEN  = 1 + EXP_W + MAN_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            in_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_overflow,
    output logic            out_underflow,
    output logic            out_invalid,
    output logic            out_zero
);
    localparam int W  = MAN_W + 4;
    localparam int EW = EXP_W + 2;
    localparam int MG = EXP_W + MAN_W;
`ifdef FPADD_RNE_EN
    localparam logic RNE = 1'b1;
`else
    localparam logic RNE = 1'b0;
`endif
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic [W-1:0]         W_ONES   = '1;
    localparam logic [XLEN-1:0]      QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [EW-1:0] EMAX     = EW'(2**EXP_W - 1);

    logic en1, en2, en3, v1, v2;

    assign en3      = !out_valid || out_ready;
    assign en2      = !v2 || en3;
    assign en1      = !v1 || en2;
    assign in_ready = en1;

    // Stage 1: unpack, classify, order by magnitude, align smaller operand
    logic             sa, sb, nan_a, nan_b, inf_a, inf_b, swap, s1_inv_c;
    logic [EXP_W-1:0] ea, eb, big_e, sml_e, diff;
    logic [MAN_W-1:0] fa, fb;
    logic [MG-1:0]    mag_a, mag_b, big_mag, sml_mag;
    logic [W-1:0]     big_x, sml_x, sml_al;
    logic [XLEN-1:0]  s1_sres_c;

    always_comb begin
        sa = in_a[XLEN-1];
        ea = in_a[MG-1:MAN_W];
        fa = in_a[MAN_W-1:0];
        sb = in_b[XLEN-1] ^ in_op;
        eb = in_b[MG-1:MAN_W];
        fb = in_b[MAN_W-1:0];
        nan_a = (ea == EXP_ONES) && (fa != '0);
        nan_b = (eb == EXP_ONES) && (fb != '0);
        inf_a = (ea == EXP_ONES) && (fa == '0);
        inf_b = (eb == EXP_ONES) && (fb == '0);
        mag_a = (ea == '0) ? '0 : in_a[MG-1:0];
        mag_b = (eb == '0) ? '0 : in_b[MG-1:0];
        swap    = mag_b > mag_a;
        big_mag = swap ? mag_b : mag_a;
        sml_mag = swap ? mag_a : mag_b;
        big_e   = big_mag[MG-1:MAN_W];
        sml_e   = sml_mag[MG-1:MAN_W];
        diff    = big_e - sml_e;
        big_x   = {|big_e, big_mag[MAN_W-1:0], 3'b000};
        sml_x   = {|sml_e, sml_mag[MAN_W-1:0], 3'b000};
        // Shifts of W or more yield zero, so huge gaps fold entirely into sticky
        sml_al    = sml_x >> diff;
        sml_al[0] = sml_al[0] | (|(sml_x & ~(W_ONES << diff)));
        s1_inv_c  = nan_a | nan_b | (inf_a & inf_b & (sa ^ sb));
        if (s1_inv_c)
            s1_sres_c = QNAN;
        else if (inf_a)
            s1_sres_c = {sa, EXP_ONES, {MAN_W{1'b0}}};
        else
            s1_sres_c = {sb, EXP_ONES, {MAN_W{1'b0}}};
    end

    logic             p1_sign, p1_sub, p1_spec, p1_inv;
    logic [EXP_W-1:0] p1_exp;
    logic [W-1:0]     p1_mb, p1_ms;
    logic [XLEN-1:0]  p1_sres;
    logic             p2_sign, p2_sub, p2_spec, p2_inv;
    logic [EXP_W-1:0] p2_exp;
    logic [W:0]       p2_sum;
    logic [XLEN-1:0]  p2_sres;

    // Stage 3: normalise, round, pack, flag
    logic signed [EW-1:0] lz, e_norm, e_fin;
    logic [W-1:0]         norm;
    logic [MAN_W:0]       man_r;
    logic                 inc, zs, ovf, unf, zro;
    logic [XLEN-1:0]      res;

    always_comb begin
        lz = EW'(W);
        for (int unsigned i = 0; i < W; i++)
            if (p2_sum[i]) lz = EW'(W - 1 - i);
        e_norm = $signed({2'b00, p2_exp});
        if (p2_sum[W]) begin
            norm   = {p2_sum[W:2], p2_sum[1] | p2_sum[0]};
            e_norm = e_norm + EW'(1);
        end else begin
            norm   = p2_sum[W-1:0] << lz;
            e_norm = e_norm - lz;
        end
        inc   = RNE & norm[2] & (norm[1] | norm[0] | norm[3]);
        man_r = {1'b0, norm[W-2:3]} + {{MAN_W{1'b0}}, inc};
        e_fin = e_norm + $signed({{(EW-1){1'b0}}, man_r[MAN_W]});
        zs    = p2_sign & ~p2_sub;
        res = '0;
        ovf = 1'b0;
        unf = 1'b0;
        zro = 1'b0;
        if (p2_spec) begin
            res = p2_sres;
        end else if (!norm[W-1]) begin
            res = {zs, {(XLEN-1){1'b0}}};
            zro = 1'b1;
        end else if (e_norm <= 0) begin
            res = {p2_sign, {(XLEN-1){1'b0}}};
            unf = 1'b1;
            zro = 1'b1;
        end else if (e_fin >= EMAX) begin
            ovf = 1'b1;
            res = RNE ? {p2_sign, EXP_ONES, {MAN_W{1'b0}}}
                      : {p2_sign, EXP_ONES - EXP_W'(1), {MAN_W{1'b1}}};
        end else begin
            res = {p2_sign, e_fin[EXP_W-1:0], man_r[MAN_W-1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0; p1_sign <= 1'b0; p1_sub <= 1'b0; p1_spec <= 1'b0; p1_inv <= 1'b0;
            p1_exp <= '0; p1_mb <= '0; p1_ms <= '0; p1_sres <= '0;
            v2 <= 1'b0; p2_sign <= 1'b0; p2_sub <= 1'b0; p2_spec <= 1'b0; p2_inv <= 1'b0;
            p2_exp <= '0; p2_sum <= '0; p2_sres <= '0;
            out_valid <= 1'b0; out_result <= '0; out_overflow <= 1'b0;
            out_underflow <= 1'b0; out_invalid <= 1'b0; out_zero <= 1'b0;
        end else begin
            if (en1) begin
                v1      <= in_valid;
                p1_sign <= swap ? sb : sa;
                p1_sub  <= sa ^ sb;
                p1_exp  <= big_e;
                p1_mb   <= big_x;
                p1_ms   <= sml_al;
                p1_spec <= nan_a | nan_b | inf_a | inf_b;
                p1_inv  <= s1_inv_c;
                p1_sres <= s1_sres_c;
            end
            if (en2) begin
                v2      <= v1;
                p2_sign <= p1_sign;
                p2_sub  <= p1_sub;
                p2_exp  <= p1_exp;
                p2_sum  <= p1_sub ? ({1'b0, p1_mb} - {1'b0, p1_ms})
                                  : ({1'b0, p1_mb} + {1'b0, p1_ms});
                p2_spec <= p1_spec;
                p2_inv  <= p1_inv;
                p2_sres <= p1_sres;
            end
            if (en3) begin
                out_valid <= v2;
                if (v2) begin
                    out_result    <= res;
                    out_overflow  <= ovf;
                    out_underflow <= unf;
                    out_invalid   <= p2_inv;
                    out_zero      <= zro;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: arithmetic vectors, specials, backpressure, reset.
module tb_fp_addsub_pipe;
    logic        clk, rst_n, in_valid, in_ready, in_op, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_result;
    logic        out_overflow, out_underflow, out_invalid, out_zero;
    int          checks, errors;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_overflow(out_overflow),
        .out_underflow(out_underflow), .out_invalid(out_invalid), .out_zero(out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // flags ordered {overflow, underflow, invalid, zero}
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic [31:0] exp_r, input logic [3:0] exp_f);
        int n;
        @(negedge clk);
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        check({tag, " rdy"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, " lat"}, n, 3);
        check({tag, " res"}, out_result, exp_r);
        check({tag, " flg"}, {out_overflow, out_underflow, out_invalid, out_zero}, exp_f);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] btab [3];
        logic [31:0] rtab [3];
        int idx, cnt;
        logic acc;
        btab = '{32'h3F800000, 32'h40000000, 32'h40400000};
        rtab = '{32'h40000000, 32'h40400000, 32'h40800000};
        checks = 0; errors = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_op = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst valid", out_valid, 0);
        check("rst result", out_result, 0);
        check("rst flags", {out_overflow, out_underflow, out_invalid, out_zero}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst in_ready", in_ready, 1);

        run_op("1.5+1.5",   32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 4'b0000);
        run_op("10-10",     32'h41200000, 32'h41200000, 1'b1, 32'h00000000, 4'b0001);
        run_op("1+(-1)",    32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'b0001);
        run_op("-0+-0",     32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0001);
        run_op("2-3",       32'h40000000, 32'h40400000, 1'b1, 32'hBF800000, 4'b0000);
        run_op("tie",       32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0000);
`ifdef FPADD_RNE_EN
        run_op("above tie", 32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0000);
        run_op("ovf",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b1000);
`else
        run_op("above tie", 32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, 4'b0000);
        run_op("ovf",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F7FFFFF, 4'b1000);
`endif
        run_op("far sticky",32'h3F800000, 32'h0D800000, 1'b0, 32'h3F800000, 4'b0000);
        run_op("inf-inf",   32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b0010);
        run_op("inf sub",   32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b0010);
        run_op("nan",       32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0010);
        run_op("inf+1",     32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000);
        run_op("1-inf",     32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000);
        run_op("sub in",    32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000);
        run_op("unf",       32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0101);

        // Backpressure: consumer stalled while producer keeps offering
        @(negedge clk);
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_a = 32'h3F800000; in_op = 1'b0;
            in_b = (idx < 3) ? btab[idx] : 32'h41000000;
            in_valid = 1'b1;
            acc = in_ready;
            @(negedge clk);
            if (acc) idx++;
        end
        check("bp accepted", idx, 3);
        check("bp in_ready", in_ready, 0);
        check("bp valid", out_valid, 1);
        check("bp head", out_result, rtab[0]);
        repeat (2) @(negedge clk);
        check("bp held", out_result, rtab[0]);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("drain%0d valid", k), out_valid, 1);
            check($sformatf("drain%0d res", k), out_result, rtab[k]);
            @(negedge clk);
        end
        check("drain empty", out_valid, 0);

        // Reset with two operations in flight
        @(negedge clk);
        in_a = 32'h3F800000; in_b = 32'h3F800000; in_op = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_b = 32'h40000000;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        check("pre-rst valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst drop valid", out_valid, 0);
        check("rst drop result", out_result, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("no stale", cnt, 0);
        check("post-rst ready", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
